// File: rtl/sr_pkg.sv
// -----------------------------------------------------------------------------
// sr_pkg
// Shared definitions for the SR flip-flop command driver.
//   - Command op encodings carried on cmd_op and stored in the FIFO.
//   - Driver FSM state type.
// -----------------------------------------------------------------------------
package sr_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;  // timed delay, s=r=0
    localparam logic [1:0] OP_RST  = 2'b01;  // drive r
    localparam logic [1:0] OP_SET  = 2'b10;  // drive s
    localparam logic [1:0] OP_BAD  = 2'b11;  // never stored, flagged as illegal

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        GAP   = 2'b10
    } state_t;

endpackage

// File: rtl/sr_cmd_fifo.sv
// -----------------------------------------------------------------------------
// sr_cmd_fifo
// Synchronous command FIFO with an occupancy counter and no bypass path.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset (flushes pointers and level)
//   push  in   write din at the tail (ignored while full)
//   pop   in   drop the head entry (ignored while empty)
//   din   in   WIDTH-bit entry to write
//   dout  out  head entry, valid while !empty
//   full  out  level == DEPTH
//   empty out  level == 0
//   level out  current occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module sr_cmd_fifo
    import sr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic             w_push;
    logic             w_pop;

    // Guarded strobes: a push while full or a pop while empty is dropped.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    assign full  = (r_level == LVL_FULL);
    assign empty = (r_level == {LW{1'b0}});
    assign level = r_level;
    assign dout  = r_mem[r_rd_ptr];

    // Storage write; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {LW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/sr_cmd_driver.sv
// -----------------------------------------------------------------------------
// sr_cmd_driver
// Buffers set/reset/hold commands and replays each onto the s/r inputs of a
// clocked SR flop for a programmed number of cycles, with a one-cycle s=r=0
// gap between consecutive commands. s and r come from a single decoded op, so
// both can never be 1 together. Also tracks the flop's expected output.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset, overrides everything
//   cmd_valid   in   command offered
//   cmd_ready   out  !full; depends on FIFO state only
//   cmd_op      in   00 hold, 01 reset, 10 set, 11 illegal
//   cmd_len     in   drive duration in cycles, 0 behaves as 1
//   s, r        out  registered flop drives
//   busy        out  FSM not idle or FIFO not empty
//   err_illegal out  sticky, an op of 11 was accepted
//   q_model     out  expected flop q
//   q_known     out  q_model is meaningful (first set/reset has been seen)
//   level       out  FIFO occupancy
// -----------------------------------------------------------------------------
module sr_cmd_driver
    import sr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [LEN_W-1:0]         cmd_len,
    output logic                     s,
    output logic                     r,
    output logic                     busy,
    output logic                     err_illegal,
    output logic                     q_model,
    output logic                     q_known,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int FW = 2 + LEN_W;
    localparam int LW = $clog2(DEPTH) + 1;

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic             r_s;
    logic             r_r;
    logic             r_err;
    logic             r_q;
    logic             r_qk;

    logic             w_full;
    logic             w_empty;
    logic [LW-1:0]    w_level;
    logic [FW-1:0]    w_dout;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_head_op;
    logic [LEN_W-1:0] w_head_len;
    logic [LEN_W-1:0] w_load_cnt;

    assign cmd_ready = !w_full;
    assign w_accept  = cmd_valid && cmd_ready;
    // Illegal ops complete the handshake but never reach the FIFO.
    assign w_push    = w_accept && (cmd_op != OP_BAD);
    // Next command is taken from IDLE or straight out of the one-cycle GAP.
    assign w_pop     = ((r_state == IDLE) || (r_state == GAP)) && !w_empty;

    assign w_head_op  = w_dout[FW-1:LEN_W];
    assign w_head_len = w_dout[LEN_W-1:0];
    // Counter holds remaining cycles after the first, so len 0 and 1 both give one cycle.
    assign w_load_cnt = (w_head_len == {LEN_W{1'b0}}) ? {LEN_W{1'b0}}
                                                      : (w_head_len - LEN_W'(1));

    sr_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({cmd_op, cmd_len}),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign s           = r_s;
    assign r           = r_r;
    assign err_illegal = r_err;
    assign q_model     = r_q;
    assign q_known     = r_qk;
    assign level       = w_level;
    assign busy        = (r_state != IDLE) || (w_level != {LW{1'b0}});

    // Command sequencer, s/r drive, sticky error and flop output tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= {LEN_W{1'b0}};
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_err   <= 1'b0;
            r_q     <= 1'b0;
            r_qk    <= 1'b0;
        end else begin
            if (w_accept && (cmd_op == OP_BAD)) begin
                r_err <= 1'b1;
            end

            // The flop samples the s/r currently presented, so follow them one edge later.
            if (r_s) begin
                r_q <= 1'b1;
            end else if (r_r) begin
                r_q <= 1'b0;
            end
            if (r_s || r_r) begin
                r_qk <= 1'b1;
            end

            case (r_state)
                IDLE, GAP: begin
                    if (w_pop) begin
                        r_state <= DRIVE;
                        r_cnt   <= w_load_cnt;
                        r_s     <= (w_head_op == OP_SET);
                        r_r     <= (w_head_op == OP_RST);
                    end else begin
                        r_state <= IDLE;
                        r_s     <= 1'b0;
                        r_r     <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (r_cnt == {LEN_W{1'b0}}) begin
                        r_state <= GAP;
                        r_s     <= 1'b0;
                        r_r     <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt - LEN_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_driver
// Directed bench for sr_cmd_driver. A reference model describes each accepted
// command as a stream of output cycles (len cycles of its drive value followed
// by one 00 cycle) fed from a command queue; every cycle the DUT outputs are
// compared against it, and literal expectations pin key cycles.
// -----------------------------------------------------------------------------
module tb_sr_cmd_driver;

    localparam int DEPTH = 4;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic             s;
    logic             r;
    logic             busy;
    logic             err_illegal;
    logic             q_model;
    logic             q_known;
    logic [2:0]       level;

    int errors = 0;
    int checks = 0;

    sr_cmd_driver #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .s           (s),
        .r           (r),
        .busy        (busy),
        .err_illegal (err_illegal),
        .q_model     (q_model),
        .q_known     (q_known),
        .level       (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int mq_op[$];
    int mq_len[$];
    int outq[$];
    bit m_s, m_r, m_eng, m_q, m_qk, m_err;
    bit model_live = 1'b0;
    int m_pre, m_o, m_l, m_v;
    bit m_acc;

    // Model advance on each clock edge using the inputs held stable since the last negedge.
    always @(posedge clk) begin
        if (rst) begin
            mq_op.delete(); mq_len.delete(); outq.delete();
            m_s = 0; m_r = 0; m_eng = 0; m_q = 0; m_qk = 0; m_err = 0;
        end else begin
            m_pre = mq_op.size();
            m_acc = (cmd_valid === 1'b1) && (m_pre < DEPTH);
            if (m_s) m_q = 1;
            else if (m_r) m_q = 0;
            if (m_s || m_r) m_qk = 1;
            if (outq.size() == 0 && mq_op.size() > 0) begin
                m_o = mq_op.pop_front();
                m_l = mq_len.pop_front();
                if (m_l == 0) m_l = 1;
                for (int k = 0; k < m_l; k++) outq.push_back(m_o);
                outq.push_back(0);
            end
            if (outq.size() > 0) begin
                m_v = outq.pop_front();
                m_eng = 1; m_s = (m_v == 2); m_r = (m_v == 1);
            end else begin
                m_eng = 0; m_s = 0; m_r = 0;
            end
            if (m_acc) begin
                if (cmd_op == 2'b11) m_err = 1;
                else begin
                    mq_op.push_back(int'(cmd_op));
                    mq_len.push_back(int'(cmd_len));
                end
            end
        end
        model_live = 1'b1;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_live) begin
            chk("s", s, m_s);
            chk("r", r, m_r);
            chk("s_and_r", s & r, 1'b0);
            chk("busy", busy, m_eng || (mq_op.size() > 0));
            chk("err_illegal", err_illegal, m_err);
            chk("q_model", q_model, m_q);
            chk("q_known", q_known, m_qk);
            chk("level", level, mq_op.size());
            chk("cmd_ready", cmd_ready, mq_op.size() < DEPTH);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Offer a command from a negedge; returns at the negedge after it is accepted.
    task automatic send(input logic [1:0] op, input logic [LEN_W-1:0] len);
        int n;
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", n < 200, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 200, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 4'd0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s", s, 1'b0);
        chk("rst_r", r, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_qk", q_known, 1'b0);
        chk("rst_level", level, 3'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single set, len 3
        send(2'b10, 4'd3);
        @(negedge clk); chk("set_s_t1", s, 1'b1); chk("set_qk_t1", q_known, 1'b0);
        @(negedge clk); chk("set_s_t2", s, 1'b1); chk("set_q_t2", q_model, 1'b1);
                        chk("set_qk_t2", q_known, 1'b1);
        @(negedge clk); chk("set_s_t3", s, 1'b1);
        @(negedge clk); chk("set_s_t4", s, 1'b0); chk("set_busy_t4", busy, 1'b1);
        wait_idle();

        // Back-to-back set len 2, reset len 1
        send(2'b10, 4'd2);
        send(2'b01, 4'd1);
        chk("b2b_s_t1", s, 1'b1);
        @(negedge clk); chk("b2b_s_t2", s, 1'b1);
        @(negedge clk); chk("b2b_gap_s", s, 1'b0); chk("b2b_gap_r", r, 1'b0);
        @(negedge clk); chk("b2b_r_t4", r, 1'b1); chk("b2b_q_t4", q_model, 1'b1);
        @(negedge clk); chk("b2b_r_t5", r, 1'b0); chk("b2b_q_t5", q_model, 1'b0);
        wait_idle();

        // Full FIFO behind a long hold
        send(2'b00, 4'd15);
        send(2'b10, 4'd4);
        send(2'b01, 4'd4);
        send(2'b10, 4'd4);
        send(2'b01, 4'd4);
        chk("full_level", level, 3'd4);
        chk("full_ready", cmd_ready, 1'b0);
        chk("full_busy", busy, 1'b1);
        send(2'b10, 4'd4);
        wait_idle();

        // Illegal op, then reset with len 0
        send(2'b11, 4'd5);
        chk("ill_err", err_illegal, 1'b1);
        chk("ill_level", level, 3'd0);
        chk("ill_busy", busy, 1'b0);
        send(2'b01, 4'd0);
        @(negedge clk); chk("len0_r_t1", r, 1'b1);
        @(negedge clk); chk("len0_r_t2", r, 1'b0); chk("len0_q_t2", q_model, 1'b0);
        wait_idle();

        // Reset in the middle of a command with two queued
        send(2'b10, 4'd8);
        send(2'b01, 4'd3);
        send(2'b10, 4'd3);
        chk("mid_level", level, 3'd2);
        chk("mid_s", s, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_s", s, 1'b0);
        chk("mid_rst_r", r, 1'b0);
        chk("mid_rst_level", level, 3'd0);
        chk("mid_rst_err", err_illegal, 1'b0);
        chk("mid_rst_qk", q_known, 1'b0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_s", s, 1'b0);
        chk("post_rst_r", r, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
